// File: rtl/ahb_resp_pkg.sv
// Shared types and constants for the AHB pixel responder.
package ahb_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR1 = 2'd3
    } state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned WCNT_W          = 4;

endpackage

// File: rtl/pixel_sram.sv
// DEPTH x 32 pixel store: one synchronous write port, one registered write-first read port.
module pixel_sram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    input  logic              i_rclr,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Array contents are deliberately not reset so preloaded images survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Write-first on a same-edge collision so a read never sees stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end else if (i_rclr) begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_pixel_responder.sv
// AHB-Lite memory responder with programmable wait states for the pixel accelerator.
// Optional ERROR response for out-of-range transfers under `define AHB_RESP_ERR_EN.
module ahb_pixel_responder
    import ahb_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic              hwrite,
    input  logic [31:0]       hwdata,
    output logic [31:0]       hrdata,
    output logic              hready,
`ifdef AHB_RESP_ERR_EN
    output logic              hresp,
`endif
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [31:0]       bd_wdata
);

    localparam logic [WCNT_W-1:0] LP_WS = WCNT_W'(WAIT_STATES);

    state_t            r_state;
    state_t            w_next;
    logic [WCNT_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_write;
    logic              r_oor;

    logic              w_hready;
    logic              w_accept;
    logic              w_oor;
    logic              w_err_xfer;
    logic [ADDR_W-1:0] w_idx;
    logic              w_cur_write;
    logic              w_cur_oor;
    logic [ADDR_W-1:0] w_cur_idx;
    logic              w_rd_fire;
    logic              w_bus_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [31:0]       w_mem_wdata;
    logic [31:0]       w_rdata;
    logic              w_unused_haddr;

    assign w_idx          = haddr[ADDR_W+1:2];
    assign w_oor          = |haddr[31:ADDR_W+2];
    assign w_unused_haddr = ^haddr[1:0];
    assign w_hready       = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign w_accept       = hsel && w_hready;

`ifdef AHB_RESP_ERR_EN
    assign w_err_xfer = w_oor;
`else
    assign w_err_xfer = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (!w_accept) begin
                    w_next = ST_IDLE;
                end else if (w_err_xfer) begin
                    w_next = ST_ERR1;
                end else if (LP_WS == '0) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wcnt == WCNT_W'(1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_ERR1: w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx   <= w_idx;
                r_write <= hwrite;
                r_oor   <= w_oor;
            end
            if (w_accept && (w_next == ST_WAIT)) begin
                r_wcnt <= LP_WS;
            end else if (r_state == ST_WAIT) begin
                r_wcnt <= r_wcnt - WCNT_W'(1);
            end
        end
    end

    // Read data is loaded on the edge entering DONE; with zero wait states that is
    // the accepting edge itself, so the transfer attributes come straight off the bus.
    assign w_cur_write = w_accept ? hwrite : r_write;
    assign w_cur_oor   = w_accept ? w_oor  : r_oor;
    assign w_cur_idx   = w_accept ? w_idx  : r_idx;
    assign w_rd_fire   = (w_next == ST_DONE) && !w_cur_write;

    // Bus write commits at the end of DONE and takes the port over the backdoor.
    assign w_bus_we    = (r_state == ST_DONE) && r_write && !r_oor;
    assign w_mem_we    = w_bus_we || bd_we;
    assign w_mem_waddr = w_bus_we ? r_idx  : bd_addr;
    assign w_mem_wdata = w_bus_we ? hwdata : bd_wdata;

    pixel_sram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_rd_fire && !w_cur_oor),
        .i_rclr  (w_rd_fire && w_cur_oor),
        .i_raddr (w_cur_idx),
        .o_rdata (w_rdata)
    );

    assign hrdata = w_rdata;
    assign hready = w_hready;

`ifdef AHB_RESP_ERR_EN
    assign hresp = ((r_state == ST_ERR1) || ((r_state == ST_DONE) && r_oor)) ? HRESP_ERROR : HRESP_OKAY;
`endif

endmodule
